// File: rtl/result_uart_sender.sv
// Serializes MATCH / NOT_MATCH result frames into bytes for a start/busy UART transmitter.
// Define RESULT_CHECKSUM_EN to append a modulo-256 sum byte to every frame.
module result_uart_sender #(
  parameter logic [7:0] HEADER       = 8'hA5,
  parameter logic [7:0] MATCH_CODE   = 8'h01,
  parameter logic [7:0] NOMATCH_CODE = 8'h02
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       send_req,
  input  logic [1:0] send_code,
  input  logic [9:0] x_in,
  input  logic [8:0] y_in,
  input  logic       tx_busy,
  output logic [7:0] tx_data,
  output logic       tx_start,
  output logic       UARTsendComplete,
  output logic       busy
);

  typedef enum logic [2:0] {StIdle, StLoad, StStart, StWaitHi, StWaitLo, StDone} state_e;

`ifdef RESULT_CHECKSUM_EN
  localparam logic [2:0] MatchLast   = 3'd6;
  localparam logic [2:0] NomatchLast = 3'd2;
`else
  localparam logic [2:0] MatchLast   = 3'd5;
  localparam logic [2:0] NomatchLast = 3'd1;
`endif

  state_e     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic       is_match_q, is_match_d;
  logic [9:0] x_q, x_d;
  logic [8:0] y_q, y_d;
  logic [2:0] last_idx;
  logic [7:0] frame_byte;
`ifdef RESULT_CHECKSUM_EN
  logic [7:0] sum_q, sum_d;
`endif

  assign last_idx = is_match_q ? MatchLast : NomatchLast;

  always_comb begin
    frame_byte = 8'h00;
    case (idx_q)
      3'd0:    frame_byte = HEADER;
      3'd1:    frame_byte = is_match_q ? MATCH_CODE : NOMATCH_CODE;
      3'd2:    frame_byte = {6'b0, x_q[9:8]};
      3'd3:    frame_byte = x_q[7:0];
      3'd4:    frame_byte = {7'b0, y_q[8]};
      3'd5:    frame_byte = y_q[7:0];
      default: frame_byte = 8'h00;
    endcase
`ifdef RESULT_CHECKSUM_EN
    // The trailing byte position carries the running sum instead of payload.
    if (idx_q == last_idx) frame_byte = sum_q;
`endif
  end

  always_comb begin
    state_d          = state_q;
    idx_d            = idx_q;
    is_match_d       = is_match_q;
    x_d              = x_q;
    y_d              = y_q;
`ifdef RESULT_CHECKSUM_EN
    sum_d            = sum_q;
`endif
    tx_data          = 8'h00;
    tx_start         = 1'b0;
    UARTsendComplete = 1'b0;
    busy             = (state_q != StIdle);
    unique case (state_q)
      StIdle: begin
        if (send_req && (send_code == 2'd1 || send_code == 2'd2)) begin
          is_match_d = (send_code == 2'd1);
          x_d        = x_in;
          y_d        = y_in;
          idx_d      = 3'd0;
`ifdef RESULT_CHECKSUM_EN
          sum_d      = 8'h00;
`endif
          state_d    = StLoad;
        end
      end
      StLoad: begin
        tx_data = frame_byte;
`ifdef RESULT_CHECKSUM_EN
        if (idx_q != last_idx) sum_d = sum_q + frame_byte;
`endif
        state_d = StStart;
      end
      StStart: begin
        tx_data  = frame_byte;
        tx_start = 1'b1;
        state_d  = StWaitHi;
      end
      StWaitHi: begin
        tx_data = frame_byte;
        if (tx_busy) state_d = StWaitLo;
      end
      StWaitLo: begin
        tx_data = frame_byte;
        if (!tx_busy) begin
          if (idx_q == last_idx) begin
            state_d = StDone;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = StLoad;
          end
        end
      end
      StDone: begin
        UARTsendComplete = 1'b1;
        state_d          = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      idx_q      <= 3'd0;
      is_match_q <= 1'b0;
      x_q        <= 10'd0;
      y_q        <= 9'd0;
`ifdef RESULT_CHECKSUM_EN
      sum_q      <= 8'h00;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      is_match_q <= is_match_d;
      x_q        <= x_d;
      y_q        <= y_d;
`ifdef RESULT_CHECKSUM_EN
      sum_q      <= sum_d;
`endif
    end
  end

endmodule
